// File: rtl/sprite_bouncer_pkg.sv
// Shared screen geometry, coordinate/colour types and the colour stepping
// helper used by the bouncing-sprite motion stage.
package sprite_bouncer_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int SPRITE_W = 128;
  localparam int SPRITE_H = 128;

  typedef logic [9:0] coord_t;
  typedef logic [2:0] color_t;

  // Colour 0 would render the sprite black, so 7 wraps straight to 1.
  function automatic color_t nextColor(input color_t c);
    return (c == 3'd7) ? 3'd1 : c + 3'd1;
  endfunction

endpackage

// File: rtl/sprite_bouncer_axis.sv
// One axis of sprite motion: position, direction and the reflect/clamp rule.
// o_bounce is combinational and says whether the next update will reflect.
module bounce_axis
  import sprite_bouncer_pkg::*;
#(
  parameter int MAX  = 512,
  parameter int STEP = 1,
  parameter int INIT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_update,
  output logic [9:0] o_pos,
  output logic       o_bounce
);

  coord_t      r_pos;
  logic        r_dirUp;
  logic [10:0] w_sumUp;
  logic        w_hitHigh;
  logic        w_hitLow;
  coord_t      w_nextPos;

  // The sum is one bit wider so a step past MAX is caught before it can wrap.
  assign w_sumUp   = {1'b0, r_pos} + 11'(STEP);
  assign w_hitHigh = r_dirUp && (w_sumUp >= 11'(MAX));
  assign w_hitLow  = !r_dirUp && (r_pos <= coord_t'(STEP));

  always_comb begin
    w_nextPos = r_pos;
    if (w_hitHigh) begin
      w_nextPos = coord_t'(MAX);
    end else if (w_hitLow) begin
      w_nextPos = '0;
    end else if (r_dirUp) begin
      w_nextPos = r_pos + coord_t'(STEP);
    end else begin
      w_nextPos = r_pos - coord_t'(STEP);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pos   <= coord_t'(INIT);
      r_dirUp <= 1'b1;
    end else if (i_update) begin
      r_pos <= w_nextPos;
      if (w_hitHigh) begin
        r_dirUp <= 1'b0;
      end else if (w_hitLow) begin
        r_dirUp <= 1'b1;
      end
    end
  end

  assign o_pos    = r_pos;
  assign o_bounce = w_hitHigh | w_hitLow;

endmodule

// File: rtl/sprite_bouncer.sv
// Bouncing-logo motion and addressing stage: moves the sprite once per frame
// and maps the beam position to sprite-local ROM coordinates one cycle later.
module sprite_bouncer
  import sprite_bouncer_pkg::*;
#(
  parameter int STEP   = 1,
  parameter int INIT_X = 0,
  parameter int INIT_Y = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       pause,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  output logic [6:0] rom_x,
  output logic [6:0] rom_y,
  output logic       sprite_on,
  output logic [2:0] color,
  output logic       corner_hit
);

  localparam int X_MAX = H_ACTIVE - SPRITE_W;
  localparam int Y_MAX = V_ACTIVE - SPRITE_H;

  logic       w_update;
  coord_t     w_posX;
  coord_t     w_posY;
  logic       w_bounceX;
  logic       w_bounceY;
  coord_t     w_dx;
  coord_t     w_dy;
  logic       w_in;
  color_t     r_color;
  logic       r_cornerHit;
  logic [6:0] r_romX;
  logic [6:0] r_romY;
  logic       r_spriteOn;

  assign w_update = frame_tick & ~pause;

  bounce_axis #(.MAX(X_MAX), .STEP(STEP), .INIT(INIT_X)) u_axisX (
    .clk      (clk),
    .rst      (rst),
    .i_update (w_update),
    .o_pos    (w_posX),
    .o_bounce (w_bounceX)
  );

  bounce_axis #(.MAX(Y_MAX), .STEP(STEP), .INIT(INIT_Y)) u_axisY (
    .clk      (clk),
    .rst      (rst),
    .i_update (w_update),
    .o_pos    (w_posY),
    .o_bounce (w_bounceY)
  );

  // A corner bounces both axes at once but still advances colour only once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_color     <= 3'b111;
      r_cornerHit <= 1'b0;
    end else begin
      r_cornerHit <= w_update & w_bounceX & w_bounceY;
      if (w_update && (w_bounceX || w_bounceY)) begin
        r_color <= nextColor(r_color);
      end
    end
  end

  // Negative offsets wrap to large values and so fail the size test for free.
  assign w_dx = hpos - w_posX;
  assign w_dy = vpos - w_posY;
  assign w_in = (hpos < coord_t'(H_ACTIVE)) && (vpos < coord_t'(V_ACTIVE)) &&
                (w_dx < coord_t'(SPRITE_W)) && (w_dy < coord_t'(SPRITE_H));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_romX     <= '0;
      r_romY     <= '0;
      r_spriteOn <= 1'b0;
    end else begin
      r_romX     <= w_dx[6:0];
      r_romY     <= w_dy[6:0];
      r_spriteOn <= w_in;
    end
  end

  assign rom_x      = r_romX;
  assign rom_y      = r_romY;
  assign sprite_on  = r_spriteOn;
  assign color      = r_color;
  assign corner_hit = r_cornerHit;

endmodule

// File: tb/tb_sprite_bouncer.sv
// Scoreboard bench for sprite_bouncer: three instances with different start
// points/steps, directed beam probes, expected responses checked by a monitor.
module tb_sprite_bouncer;

  typedef struct {
    int         dut;
    string      name;
    logic [6:0] rx;
    logic [6:0] ry;
    logic       on;
    logic [2:0] col;
    logic       cor;
  } exp_t;

  logic            clk;
  logic            rst;
  logic [2:0]      ft;
  logic            pause;
  logic [9:0]      hpos;
  logic [9:0]      vpos;
  logic [2:0][6:0] romX;
  logic [2:0][6:0] romY;
  logic [2:0]      spriteOn;
  logic [2:0][2:0] colorOut;
  logic [2:0]      cornerHit;

  exp_t sbQ[$];
  int   checks   = 0;
  int   failures = 0;
  event asyncProbe;

  // d0: STEP 1 from (0,0); d1: STEP 2 from (510,350); d2: STEP 1 from (511,100)
  sprite_bouncer #(.STEP(1), .INIT_X(0), .INIT_Y(0)) u_d0 (
    .clk(clk), .rst(rst), .frame_tick(ft[0]), .pause(pause), .hpos(hpos), .vpos(vpos),
    .rom_x(romX[0]), .rom_y(romY[0]), .sprite_on(spriteOn[0]), .color(colorOut[0]),
    .corner_hit(cornerHit[0])
  );

  sprite_bouncer #(.STEP(2), .INIT_X(510), .INIT_Y(350)) u_d1 (
    .clk(clk), .rst(rst), .frame_tick(ft[1]), .pause(pause), .hpos(hpos), .vpos(vpos),
    .rom_x(romX[1]), .rom_y(romY[1]), .sprite_on(spriteOn[1]), .color(colorOut[1]),
    .corner_hit(cornerHit[1])
  );

  sprite_bouncer #(.STEP(1), .INIT_X(511), .INIT_Y(100)) u_d2 (
    .clk(clk), .rst(rst), .frame_tick(ft[2]), .pause(pause), .hpos(hpos), .vpos(vpos),
    .rom_x(romX[2]), .rom_y(romY[2]), .sprite_on(spriteOn[2]), .color(colorOut[2]),
    .corner_hit(cornerHit[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs at the falling edge; they are sampled on the next rise.
  task automatic applyStimulus(input logic [2:0] ftv, input logic p,
                               input logic [9:0] h, input logic [9:0] v);
    @(negedge clk);
    ft    = ftv;
    pause = p;
    hpos  = h;
    vpos  = v;
  endtask

  task automatic checkOutput(input int d, input string nm, input logic [6:0] rx,
                             input logic [6:0] ry, input logic on,
                             input logic [2:0] col, input logic cor);
    exp_t e;
    e.dut  = d;
    e.name = nm;
    e.rx   = rx;
    e.ry   = ry;
    e.on   = on;
    e.col  = col;
    e.cor  = cor;
    sbQ.push_back(e);
  endtask

  // Monitor: after each rising edge (or an asynchronous probe) compare everything queued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or asyncProbe);
      #1;
      while (sbQ.size() > 0) begin
        e = sbQ.pop_front();
        checks++;
        if (romX[e.dut] !== e.rx || romY[e.dut] !== e.ry || spriteOn[e.dut] !== e.on ||
            colorOut[e.dut] !== e.col || cornerHit[e.dut] !== e.cor) begin
          failures++;
          $display("[TB] FAIL %s dut%0d: got rom=(%0d,%0d) on=%0b color=%0d corner=%0b, want rom=(%0d,%0d) on=%0b color=%0d corner=%0b",
                   e.name, e.dut, romX[e.dut], romY[e.dut], spriteOn[e.dut],
                   colorOut[e.dut], cornerHit[e.dut], e.rx, e.ry, e.on, e.col, e.cor);
        end
      end
    end
  end

  initial begin
    rst   = 1'b1;
    ft    = 3'b000;
    pause = 1'b0;
    hpos  = '0;
    vpos  = '0;

    applyStimulus(3'b000, 1'b0, 10'd0, 10'd0);
    checkOutput(0, "reset_d0", 7'd0, 7'd0, 1'b0, 3'd7, 1'b0);
    checkOutput(1, "reset_d1", 7'd0, 7'd0, 1'b0, 3'd7, 1'b0);
    checkOutput(2, "reset_d2", 7'd0, 7'd0, 1'b0, 3'd7, 1'b0);
    applyStimulus(3'b000, 1'b0, 10'd0, 10'd0);
    rst = 1'b0;

    // d0 basic motion and addressing
    applyStimulus(3'b000, 1'b0, 10'd0, 10'd0);
    checkOutput(0, "d0_home", 7'd0, 7'd0, 1'b1, 3'd7, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(3'b001, 1'b0, 10'd0, 10'd0);
      applyStimulus(3'b000, 1'b0, 10'd0, 10'd0);
    end
    applyStimulus(3'b000, 1'b0, 10'd3, 10'd3);
    checkOutput(0, "d0_after_3_ticks", 7'd0, 7'd0, 1'b1, 3'd7, 1'b0);
    applyStimulus(3'b000, 1'b0, 10'd2, 10'd3);
    checkOutput(0, "d0_left_of_sprite", 7'd127, 7'd0, 1'b0, 3'd7, 1'b0);
    applyStimulus(3'b000, 1'b0, 10'd130, 10'd130);
    checkOutput(0, "d0_far_corner", 7'd127, 7'd127, 1'b1, 3'd7, 1'b0);

    for (int i = 0; i < 97; i++) begin
      applyStimulus(3'b001, 1'b0, 10'd0, 10'd0);
      applyStimulus(3'b000, 1'b0, 10'd0, 10'd0);
    end
    applyStimulus(3'b000, 1'b0, 10'd100, 10'd100);
    checkOutput(0, "d0_at_100", 7'd0, 7'd0, 1'b1, 3'd7, 1'b0);
    applyStimulus(3'b000, 1'b0, 10'd227, 10'd227);
    checkOutput(0, "d0_last_pixel", 7'd127, 7'd127, 1'b1, 3'd7, 1'b0);
    applyStimulus(3'b000, 1'b0, 10'd228, 10'd100);
    checkOutput(0, "d0_right_edge", 7'd0, 7'd0, 1'b0, 3'd7, 1'b0);
    applyStimulus(3'b000, 1'b0, 10'd99, 10'd100);
    checkOutput(0, "d0_left_edge", 7'd127, 7'd0, 1'b0, 3'd7, 1'b0);

    // Pause freezes motion; an unpaused tick's cycle still addresses with the old position
    for (int i = 0; i < 5; i++) begin
      applyStimulus(3'b001, 1'b1, 10'd100, 10'd100);
      applyStimulus(3'b000, 1'b1, 10'd100, 10'd100);
    end
    applyStimulus(3'b000, 1'b0, 10'd100, 10'd100);
    checkOutput(0, "d0_paused", 7'd0, 7'd0, 1'b1, 3'd7, 1'b0);
    applyStimulus(3'b001, 1'b0, 10'd100, 10'd100);
    checkOutput(0, "d0_tick_old_pos", 7'd0, 7'd0, 1'b1, 3'd7, 1'b0);
    applyStimulus(3'b000, 1'b0, 10'd101, 10'd101);
    checkOutput(0, "d0_moved_to_101", 7'd0, 7'd0, 1'b1, 3'd7, 1'b0);
    applyStimulus(3'b000, 1'b0, 10'd100, 10'd100);
    checkOutput(0, "d0_old_pos_off", 7'd127, 7'd127, 1'b0, 3'd7, 1'b0);

    // d2: single x bounce at the right edge
    for (int i = 0; i < 5; i++) begin
      applyStimulus(3'b100, 1'b1, 10'd511, 10'd100);
      applyStimulus(3'b000, 1'b1, 10'd511, 10'd100);
    end
    applyStimulus(3'b000, 1'b0, 10'd511, 10'd100);
    checkOutput(2, "d2_paused", 7'd0, 7'd0, 1'b1, 3'd7, 1'b0);
    applyStimulus(3'b100, 1'b0, 10'd511, 10'd100);
    checkOutput(2, "d2_bounce_x", 7'd0, 7'd0, 1'b1, 3'd1, 1'b0);
    applyStimulus(3'b000, 1'b0, 10'd512, 10'd101);
    checkOutput(2, "d2_at_xmax", 7'd0, 7'd0, 1'b1, 3'd1, 1'b0);
    applyStimulus(3'b100, 1'b0, 10'd512, 10'd101);
    checkOutput(2, "d2_leave_edge", 7'd0, 7'd0, 1'b1, 3'd1, 1'b0);
    applyStimulus(3'b000, 1'b0, 10'd511, 10'd102);
    checkOutput(2, "d2_back_511", 7'd0, 7'd0, 1'b1, 3'd1, 1'b0);
    applyStimulus(3'b000, 1'b0, 10'd512, 10'd102);
    checkOutput(2, "d2_offset_1", 7'd1, 7'd0, 1'b1, 3'd1, 1'b0);

    // d1: corner hit with STEP 2
    applyStimulus(3'b010, 1'b0, 10'd510, 10'd350);
    checkOutput(1, "d1_corner", 7'd0, 7'd0, 1'b1, 3'd1, 1'b1);
    applyStimulus(3'b000, 1'b0, 10'd512, 10'd352);
    checkOutput(1, "d1_corner_pulse_end", 7'd0, 7'd0, 1'b1, 3'd1, 1'b0);
    applyStimulus(3'b000, 1'b0, 10'd639, 10'd479);
    checkOutput(1, "d1_screen_corner", 7'd127, 7'd127, 1'b1, 3'd1, 1'b0);
    applyStimulus(3'b000, 1'b0, 10'd640, 10'd352);
    checkOutput(1, "d1_hblank", 7'd0, 7'd0, 1'b0, 3'd1, 1'b0);
    applyStimulus(3'b010, 1'b0, 10'd512, 10'd352);
    checkOutput(1, "d1_reverse_tick", 7'd0, 7'd0, 1'b1, 3'd1, 1'b0);
    applyStimulus(3'b000, 1'b0, 10'd510, 10'd350);
    checkOutput(1, "d1_moved_back", 7'd0, 7'd0, 1'b1, 3'd1, 1'b0);

    // Asynchronous reset while the sprite is visible
    applyStimulus(3'b000, 1'b0, 10'd101, 10'd101);
    checkOutput(0, "d0_pre_reset", 7'd0, 7'd0, 1'b1, 3'd7, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    checkOutput(0, "d0_async_reset", 7'd0, 7'd0, 1'b0, 3'd7, 1'b0);
    checkOutput(1, "d1_async_reset", 7'd0, 7'd0, 1'b0, 3'd7, 1'b0);
    ->asyncProbe;
    applyStimulus(3'b000, 1'b0, 10'd0, 10'd0);
    applyStimulus(3'b000, 1'b0, 10'd0, 10'd0);
    rst = 1'b0;
    applyStimulus(3'b000, 1'b0, 10'd0, 10'd0);
    checkOutput(0, "d0_pos_init", 7'd0, 7'd0, 1'b1, 3'd7, 1'b0);
    applyStimulus(3'b001, 1'b0, 10'd0, 10'd0);
    checkOutput(0, "d0_resume_tick", 7'd0, 7'd0, 1'b1, 3'd7, 1'b0);
    applyStimulus(3'b000, 1'b0, 10'd1, 10'd1);
    checkOutput(0, "d0_resumed", 7'd0, 7'd0, 1'b1, 3'd7, 1'b0);

    applyStimulus(3'b000, 1'b0, 10'd0, 10'd0);
    applyStimulus(3'b000, 1'b0, 10'd0, 10'd0);
    checks++;
    if (sbQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, want 0", sbQ.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sprite_bouncer.md
Name: sprite_bouncer

Overview:
- Motion and addressing stage directly upstream of the 128x128 logo bitmap ROM.
- Holds the bouncing sprite's screen position and moves it once per frame inside the 640x480 active area.
- Reflects direction at each edge and steps a colour index on every bounce.
- Each cycle, converts the VGA beam position (hpos, vpos) into sprite-local rom_x/rom_y plus a sprite_on qualifier; downstream combines sprite_on with the ROM pixel and colour.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- SPRITE_W, 128, sprite width in screen pixels; matches the ROM x range
- SPRITE_H, 128, sprite height in screen pixels; matches the ROM y range
- STEP, 1, pixels moved per axis per frame; legal range 1..15
- INIT_X, 0, reset x position
- INIT_Y, 0, reset y position

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous active-high reset
- frame_tick  in  1  one-cycle pulse, issued once per frame during vertical blanking
- pause  in  1  when high, position, direction and colour are frozen
- hpos  in  10  beam column from the VGA timing block
- vpos  in  10  beam row from the VGA timing block
- rom_x  out  7  sprite-local column to the bitmap ROM
- rom_y  out  7  sprite-local row to the bitmap ROM
- sprite_on  out  1  beam is inside the sprite rectangle and in the active area
- color  out  3  RGB111 colour index for the sprite, never 0
- corner_hit  out  1  one-cycle pulse when x and y bounce on the same update

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values:
  - pos_x=INIT_X, pos_y=INIT_Y
  - dir_x=+, dir_y=+
  - color=3'b111
  - rom_x=0, rom_y=0, sprite_on=0, corner_hit=0
- Position limits: X_MAX=H_ACTIVE-SPRITE_W (512), Y_MAX=V_ACTIVE-SPRITE_H (352). pos_x and pos_y are 10-bit unsigned.
- Update condition: state changes only in the cycle after a frame_tick with pause=0. frame_tick with pause=1 is ignored. No mid-frame position change, so no tearing.
- Per-axis update (x shown; y is identical with Y_MAX):
  - dir + and pos_x+STEP >= X_MAX: pos_x<=X_MAX, dir<=-, bounce_x=1.
  - dir - and pos_x <= STEP: pos_x<=0, dir<=+, bounce_x=1.
  - otherwise: pos_x<=pos_x±STEP.
  - Clamping guarantees pos never leaves [0, X_MAX]; no wrap-around.
- Colour:
  - If bounce_x|bounce_y, color<=color+1. Any value of 7 is followed by 1 (0 is skipped).
  - A corner (both bounces on the same update) advances colour by exactly one step.
- corner_hit: high for exactly one cycle, coincident with the update, when bounce_x&bounce_y.
- Addressing pipeline, 1-cycle latency:
  - dx=hpos-pos_x and dy=vpos-pos_y, computed 10-bit with wrap.
  - in = (hpos<H_ACTIVE) & (vpos<V_ACTIVE) & (dx<SPRITE_W) & (dy<SPRITE_H).
  - Registered: rom_x<=dx[6:0], rom_y<=dy[6:0], sprite_on<=in.
  - Outside the sprite, rom_x/rom_y still carry the truncated dx/dy (don't-care downstream). Downstream must gate with sprite_on.
- frame_tick and addressing in the same cycle: addressing uses the pre-update position.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronous). Motion resumes on the first frame_tick after rst deasserts.

Decomposition:
- Shared package holds:
  - H_ACTIVE, V_ACTIVE, SPRITE_W, SPRITE_H defaults
  - the 10-bit coordinate type
  - the 3-bit colour type
- One natural sub-module: bounce_axis. It holds pos/dir/clamp logic for one axis, is parameterised by MAX and STEP, and outputs pos and a bounce flag. It is instantiated twice, for x and y.
- Colour, corner detect and the addressing pipeline stay in sprite_bouncer.

Test Plan:
- Reset at INIT=(0,0), 3 frame_ticks with STEP=1 -> pos=(3,3), color=7, dir both +.
- Drive to pos_x=511, dir +, one tick -> pos_x=512, dir -, color 7->1, corner_hit=0. Next tick -> pos_x=511.
- INIT=(510,350), STEP=2, one tick -> pos=(512,352), both dirs flip, color advances by exactly 1, corner_hit pulses for 1 cycle.
- pos=(100,50), beam (100,50) -> next cycle rom_x=0, rom_y=0, sprite_on=1. Beam (227,177) -> rom=(127,127), on=1. Beam (228,50) -> on=0. Beam (99,50) -> on=0.
- pause=1 held across 5 frame_ticks -> pos, dir and color unchanged. pause=0 with frame_tick in the same cycle as beam (pos_x,pos_y) -> sprite_on uses the old position.
- Assert rst mid-frame with sprite_on=1 -> sprite_on, rom_x, rom_y go to 0 without a clock edge, and pos returns to INIT.
